reservation_station_pool: RTL and testbench
===========================================

// Module: reservation_station_pool
// PURPOSE
//  Multi-entry reservation station: holds up to DEPTH renamed instructions for one functional unit.
//  Snoops the tag-indexed CDB to capture operands and issues the oldest ready entry each cycle.
//  Sits between dispatch (instruction queue/regfile/ROB) and its ALU/branch unit.
//  Squashes entries whose ROB tag is invalidated.
// PARAMETERS
//  DEPTH     4   number of entries (>=2)
//  ROB_TAGS  8   ROB entries; CDB array and tag vectors are this wide
//  TAG_W     3   ROB tag width, $clog2(ROB_TAGS)
//  XLEN      32  operand/data width
// PORTS
//  clk                 in   1              clock; all state updates on posedge
//  rst                 in   1              reset, asynchronous, active-high
//  alloc_valid         in   1              dispatch presents alloc_word this cycle
//  alloc_word          in   res_word       opcode/funct3/funct7/src1,2 {tag,data,valid}/rd_tag/pc
//  alloc_ready         out  1              ~full; alloc accepted iff alloc_valid & alloc_ready
//  cdb                 in   cdb_data[ROB_TAGS]  result data indexed by ROB tag
//  robs_calculated     in   ROB_TAGS       bit t set: cdb[t].data is valid this cycle
//  invalidated_rob_n   in   ROB_TAGS       bit t low: ROB tag t flushed
//  issue_valid         out  1              issue_data holds a ready entry
//  issue_ready         in   1              FU accepts; entry freed at edge when valid&ready
//  issue_data          out  alu_word       opcode/funct3/funct7/tag/pc/src1_data/src2_data
//  ld_pc_to_cdb        out  1              issued op is jalr or branch
//  update_br           out  1              issued op is branch
//  jalr_executed       out  1              issued op is jalr (fires on handshake only)
//  jalr_tag            out  TAG_W          rd_tag of issued entry
//  occupancy           out  $clog2(DEPTH+1)  live entries
//  res_empty           out  1              occupancy == 0
// BEHAVIOUR
//  Reset: all entries FREE, age matrix cleared. Outputs: alloc_ready=1, res_empty=1, occupancy=0;
//  issue_valid, flags, jalr_tag and issue_data all 0.
//  Entry state: FREE / BUSY. BUSY entry is ready when each source is valid or its
//  robs_calculated[tag] bit is set this cycle.
//  Alloc: written into the lowest-index FREE entry at posedge and marked youngest.
//  Source with valid=0 and robs_calculated[tag]=1 in the alloc cycle captures cdb data at the same edge.
//  Wakeup: BUSY entry with invalid src and robs_calculated[tag]=1 latches cdb[tag].data,
//  valid<=1 at posedge. Several entries may capture from the same tag in the same cycle.
//  Issue select: the oldest ready, non-flushed entry; combinational.
//  Operand bypass: a src not yet valid drives cdb[tag].data onto issue_data.
//  Min latency: alloc edge -> issue_valid in the next cycle (1 cycle); no same-cycle alloc->issue.
//  Handshake: issue_valid does not depend on issue_ready. Selection may change while stalled
//  only if an older entry becomes ready. Entry is freed at the edge where valid&ready.
//  Flags: jalr/branch flags are decoded from the selected opcode and gated by issue_valid;
//  jalr_executed is additionally gated by issue_ready. Outside issue_valid, issue_data is 0.
//  Flush: every BUSY entry with invalidated_rob_n[rd_tag]=0 goes FREE at posedge and is excluded
//  from select in that cycle. An alloc_word whose rd_tag is flushed is dropped; alloc_ready is unaffected.
//  Full: alloc_ready=0 when occupancy==DEPTH, even if an issue or flush frees an entry that cycle.
//  Simultaneous alloc+issue+flush: each is applied independently.
//  occupancy' = occupancy + alloc - issue - flushed.
//  Reset mid-operation: state clears immediately (async); no partial issue completes.
// STRUCTURE
//  tomasula_types package: res_word, alu_word, cdb_data, opcode enum (s_op_jalr, s_op_br, ...),
//  plus new rs_entry_t {busy, res_word}.
//  Sub-module rs_age_matrix #(DEPTH): DEPTH x DEPTH older-than bits.
//  Inputs: set-youngest index, clear-on-free vector. Output: one-hot oldest among a request mask.
//  Top level holds the entry array, wakeup/bypass muxes, free-slot priority encoder and flags.
// TESTING
//  1 Alloc add, both srcs valid (5, 7), issue_ready=1 -> issue_valid next cycle, src data 5/7,
//    entry freed, res_empty=1.
//  2 Alloc with src1 tag 3 pending; two cycles later robs_calculated[3]=1, cdb[3]=0x2A
//    -> issue same cycle with src1=0x2A (bypass); also checks latched path with issue_ready=0 then 1.
//  3 Fill DEPTH=4 entries, all ready, issue_ready=1 -> issue in alloc order.
//    alloc_ready=0 while full; 5th alloc held until occupancy=3.
//  4 Entries A (older, waiting) and B (younger, ready) -> B issues first.
//    When A wakes, A issues before a later-ready C.
//  5 jalr rd_tag 2 issued under handshake -> jalr_executed=1, ld_pc_to_cdb=1, jalr_tag=2.
//    Branch -> update_br=1, ld_pc_to_cdb=1.
//  6 invalidated_rob_n[4]=0 while tag-4 entry is ready and issue_ready=1 -> no issue, entry freed.
//    Alloc with rd_tag 4 that cycle dropped. Async rst mid-stall -> all outputs at reset values.

Source files
------------

// File: rtl/reservation_station_pool_pkg.sv
// rtl/reservation_station_pool_pkg.sv - shared types, sizes and operand helpers for the reservation station
// Contents: sizing localparams, opcode enum, dispatch word (res_word), issue word (alu_word),
// CDB slot (cdb_data), entry record (rs_entry_t), and source resolve/capture/bypass helpers.
package reservation_station_pool_pkg;

    localparam int RS_DEPTH = 4;
    localparam int ROB_TAGS = 8;
    localparam int TAG_W    = $clog2(ROB_TAGS);
    localparam int XLEN     = 32;
    localparam int OCC_W    = $clog2(RS_DEPTH + 1);

    typedef enum logic [6:0] {
        s_op_alu  = 7'b0110011,
        s_op_alui = 7'b0010011,
        s_op_lui  = 7'b0110111,
        s_op_jalr = 7'b1100111,
        s_op_br   = 7'b1100011
    } opcode_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
        logic             valid;
    } src_operand_t;

    typedef struct packed {
        opcode_t          opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        src_operand_t     src1;
        src_operand_t     src2;
        logic [TAG_W-1:0] rd_tag;
        logic [XLEN-1:0]  pc;
    } res_word;

    typedef struct packed {
        opcode_t          opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  src1_data;
        logic [XLEN-1:0]  src2_data;
    } alu_word;

    typedef struct packed {
        logic [XLEN-1:0] data;
    } cdb_data;

    typedef cdb_data [ROB_TAGS-1:0] cdb_bus;

    typedef struct packed {
        logic    busy;
        res_word word;
    } rs_entry_t;

    // A source is usable this cycle if already captured or being broadcast now.
    function automatic logic src_resolved(src_operand_t s, logic [ROB_TAGS-1:0] calc);
        return s.valid | calc[s.tag];
    endfunction

    // Latch a broadcast result into a still-pending source.
    function automatic src_operand_t capture_src(src_operand_t s, logic [ROB_TAGS-1:0] calc, cdb_bus cdb);
        src_operand_t r = s;
        if (!s.valid && calc[s.tag]) begin
            r.data  = cdb[s.tag].data;
            r.valid = 1'b1;
        end
        return r;
    endfunction

    // Value seen by the FU: captured data, or the CDB slot bypassed when still pending.
    function automatic logic [XLEN-1:0] src_value(src_operand_t s, cdb_bus cdb);
        return s.valid ? s.data : cdb[s.tag].data;
    endfunction

endpackage

// File: rtl/reservation_station_pool_if.sv
// rtl/reservation_station_pool_if.sv - dispatch, CDB snoop and issue signals of the reservation station
// slave  : the reservation station (consumes alloc/CDB/flush/issue_ready, drives the rest)
// master : the surrounding pipeline (dispatch, ROB, CDB and functional unit)
interface reservation_station_pool_if;
    import reservation_station_pool_pkg::*;

    logic                alloc_valid;
    res_word             alloc_word;
    logic                alloc_ready;
    cdb_bus              cdb;
    logic [ROB_TAGS-1:0] robs_calculated;
    logic [ROB_TAGS-1:0] invalidated_rob_n;
    logic                issue_valid;
    logic                issue_ready;
    alu_word             issue_data;
    logic                ld_pc_to_cdb;
    logic                update_br;
    logic                jalr_executed;
    logic [TAG_W-1:0]    jalr_tag;
    logic [OCC_W-1:0]    occupancy;
    logic                res_empty;

    modport slave (
        input  alloc_valid, alloc_word, cdb, robs_calculated, invalidated_rob_n, issue_ready,
        output alloc_ready, issue_valid, issue_data, ld_pc_to_cdb, update_br, jalr_executed,
               jalr_tag, occupancy, res_empty
    );

    modport master (
        output alloc_valid, alloc_word, cdb, robs_calculated, invalidated_rob_n, issue_ready,
        input  alloc_ready, issue_valid, issue_data, ld_pc_to_cdb, update_br, jalr_executed,
               jalr_tag, occupancy, res_empty
    );

endinterface

// File: rtl/reservation_station_pool_age_matrix.sv
// rtl/reservation_station_pool_age_matrix.sv - DEPTH x DEPTH older-than matrix picking the oldest requester
// Ports: clk, rst (async, active-high); i_set_valid/i_set_idx mark an entry youngest;
// i_clear frees entries; i_req is the request mask; o_oldest is one-hot oldest requester (or 0).
module rs_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_set_valid,
    input  logic [$clog2(DEPTH)-1:0] i_set_idx,
    input  logic [DEPTH-1:0]         i_clear,
    input  logic [DEPTH-1:0]         i_req,
    output logic [DEPTH-1:0]         o_oldest
);

    // r_older[i][j] = 1: entry i was allocated before entry j.
    logic [DEPTH-1:0] r_older [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (i_set_valid && j == int'(i_set_idx)) begin
                        r_older[i][j] <= (i != j) && !i_clear[i];
                    end else if (i_set_valid && i == int'(i_set_idx)) begin
                        r_older[i][j] <= 1'b0;
                    end else if (i_clear[i] || i_clear[j]) begin
                        r_older[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // A requester wins when no other requester is older than it.
    always_comb begin
        o_oldest = '0;
        for (int j = 0; j < DEPTH; j++) begin
            o_oldest[j] = i_req[j];
            for (int i = 0; i < DEPTH; i++) begin
                if (i_req[i] && r_older[i][j]) begin
                    o_oldest[j] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/reservation_station_pool.sv
// rtl/reservation_station_pool.sv - reservation station: CDB wakeup, oldest-ready issue, ROB-tag squash
// Ports: clk, rst (async, active-high); rs (slave modport) carrying alloc handshake, CDB array,
// robs_calculated/invalidated_rob_n vectors, issue handshake + issue_data, branch/jalr flags,
// occupancy and res_empty.
module reservation_station_pool (
    input  logic                       clk,
    input  logic                       rst,
    reservation_station_pool_if.slave  rs
);
    import reservation_station_pool_pkg::*;

    localparam int IDX_W = $clog2(RS_DEPTH);

    rs_entry_t        r_entry [RS_DEPTH];
    logic [RS_DEPTH-1:0] w_busy, w_ready, w_flushed, w_req, w_grant, w_freed;
    logic             w_full, w_alloc, w_issue_valid, w_fire, w_is_jalr, w_is_br;
    logic [IDX_W-1:0] w_alloc_idx;
    res_word          w_sel, w_alloc_word;
    alu_word          w_issue_data;

    always_comb begin
        w_busy    = '0;
        w_ready   = '0;
        w_flushed = '0;
        for (int k = 0; k < RS_DEPTH; k++) begin
            w_busy[k]    = r_entry[k].busy;
            w_ready[k]   = r_entry[k].busy
                         & src_resolved(r_entry[k].word.src1, rs.robs_calculated)
                         & src_resolved(r_entry[k].word.src2, rs.robs_calculated);
            w_flushed[k] = r_entry[k].busy & ~rs.invalidated_rob_n[r_entry[k].word.rd_tag];
        end
    end

    // Entries squashed this cycle may not be selected even if their operands are ready.
    assign w_req         = w_ready & ~w_flushed;
    assign w_issue_valid = |w_grant;
    assign w_fire        = w_issue_valid & rs.issue_ready;
    assign w_freed       = (w_fire ? w_grant : '0) | w_flushed;

    // Full is judged on current occupancy, so a same-cycle issue/flush does not open a slot.
    assign w_full  = &w_busy;
    assign w_alloc = rs.alloc_valid & ~w_full & rs.invalidated_rob_n[rs.alloc_word.rd_tag];

    always_comb begin
        w_alloc_idx = '0;
        for (int k = RS_DEPTH - 1; k >= 0; k--) begin
            if (!w_busy[k]) begin
                w_alloc_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        w_alloc_word      = rs.alloc_word;
        w_alloc_word.src1 = capture_src(rs.alloc_word.src1, rs.robs_calculated, rs.cdb);
        w_alloc_word.src2 = capture_src(rs.alloc_word.src2, rs.robs_calculated, rs.cdb);
    end

    rs_age_matrix #(.DEPTH(RS_DEPTH)) u_age (
        .clk         (clk),
        .rst         (rst),
        .i_set_valid (w_alloc),
        .i_set_idx   (w_alloc_idx),
        .i_clear     (w_freed),
        .i_req       (w_req),
        .o_oldest    (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RS_DEPTH; k++) begin
                r_entry[k] <= '0;
            end
        end else begin
            for (int k = 0; k < RS_DEPTH; k++) begin
                if (w_alloc && w_alloc_idx == IDX_W'(k)) begin
                    r_entry[k].busy <= 1'b1;
                    r_entry[k].word <= w_alloc_word;
                end else if (w_freed[k]) begin
                    r_entry[k].busy <= 1'b0;
                end else if (w_busy[k]) begin
                    r_entry[k].word.src1 <= capture_src(r_entry[k].word.src1, rs.robs_calculated, rs.cdb);
                    r_entry[k].word.src2 <= capture_src(r_entry[k].word.src2, rs.robs_calculated, rs.cdb);
                end
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < RS_DEPTH; k++) begin
            if (w_grant[k]) begin
                w_sel = r_entry[k].word;
            end
        end
    end

    always_comb begin
        w_issue_data = '0;
        if (w_issue_valid) begin
            w_issue_data.opcode    = w_sel.opcode;
            w_issue_data.funct3    = w_sel.funct3;
            w_issue_data.funct7    = w_sel.funct7;
            w_issue_data.tag       = w_sel.rd_tag;
            w_issue_data.pc        = w_sel.pc;
            w_issue_data.src1_data = src_value(w_sel.src1, rs.cdb);
            w_issue_data.src2_data = src_value(w_sel.src2, rs.cdb);
        end
    end

    assign w_is_jalr = (w_sel.opcode == s_op_jalr);
    assign w_is_br   = (w_sel.opcode == s_op_br);

    assign rs.alloc_ready   = ~w_full;
    assign rs.issue_valid   = w_issue_valid;
    assign rs.issue_data    = w_issue_data;
    assign rs.ld_pc_to_cdb  = w_issue_valid & (w_is_jalr | w_is_br);
    assign rs.update_br     = w_issue_valid & w_is_br;
    assign rs.jalr_executed = w_fire & w_is_jalr;
    assign rs.jalr_tag      = w_issue_valid ? w_sel.rd_tag : '0;
    assign rs.occupancy     = OCC_W'($countones(w_busy));
    assign rs.res_empty     = ~|w_busy;

endmodule

// File: tb/tb_reservation_station_pool.sv
// tb/tb_reservation_station_pool.sv - scoreboard bench for reservation_station_pool
module tb_reservation_station_pool;
    import reservation_station_pool_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reservation_station_pool_if rs_if ();

    reservation_station_pool dut (
        .clk (clk),
        .rst (rst),
        .rs  (rs_if)
    );

    typedef struct {
        int          cyc;
        alu_word     data;
        logic        ld_pc;
        logic        upd_br;
        logic        jalr_ex;
        logic [TAG_W-1:0] jtag;
    } exp_t;

    exp_t    exp_q[$];
    res_word model_q[$];     // live instructions, oldest first
    int      compared   = 0;
    int      mismatched = 0;
    int      cyc        = 0;

    logic                st_av;
    res_word             st_w;
    cdb_bus              st_cdb;
    logic [ROB_TAGS-1:0] st_rc;
    logic [ROB_TAGS-1:0] st_inv;
    logic                st_ir;

    opcode_t ops [4] = '{s_op_alu, s_op_alui, s_op_jalr, s_op_br};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit src_ok(src_operand_t s);
        return s.valid || st_rc[s.tag];
    endfunction

    function automatic logic [XLEN-1:0] src_val(src_operand_t s);
        if (s.valid) return s.data;
        return st_cdb[s.tag].data;
    endfunction

    function automatic res_word wake(res_word w);
        res_word r = w;
        if (!r.src1.valid && st_rc[r.src1.tag]) begin r.src1.data = st_cdb[r.src1.tag].data; r.src1.valid = 1'b1; end
        if (!r.src2.valid && st_rc[r.src2.tag]) begin r.src2.data = st_cdb[r.src2.tag].data; r.src2.valid = 1'b1; end
        return r;
    endfunction

    function automatic res_word mk(opcode_t op, logic v1, int t1, logic [31:0] d1,
                                   logic v2, int t2, logic [31:0] d2, int rd);
        res_word w = '0;
        w.opcode     = op;
        w.funct3     = 3'(rd);
        w.funct7     = 7'(rd * 3);
        w.src1.valid = v1; w.src1.tag = TAG_W'(t1); w.src1.data = d1;
        w.src2.valid = v2; w.src2.tag = TAG_W'(t2); w.src2.data = d2;
        w.rd_tag     = TAG_W'(rd);
        w.pc         = 32'h1000 + 32'(rd * 4);
        return w;
    endfunction

    task automatic idle();
        st_av = 1'b0; st_w = '0; st_cdb = '0; st_rc = '0; st_inv = '1; st_ir = 1'b0;
    endtask

    task automatic rand_stim();
        st_av = ($urandom_range(0, 9) < 6);
        st_w  = mk(ops[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 7)));
        st_w.pc = $urandom;
        for (int t = 0; t < ROB_TAGS; t++) begin
            st_cdb[t].data = $urandom;
            st_rc[t]       = ($urandom_range(0, 3) == 0);
        end
        st_inv = '1;
        if ($urandom_range(0, 15) == 0) st_inv[$urandom_range(0, ROB_TAGS - 1)] = 1'b0;
        st_ir = ($urandom_range(0, 9) < 7);
    endtask

    // One clock cycle: drive, check state outputs, predict issue, advance the model.
    task automatic step(input bit do_rst);
        res_word nq[$];
        int      sel = -1;
        exp_t    e;
        rs_if.alloc_valid       = st_av;
        rs_if.alloc_word        = st_w;
        rs_if.cdb               = st_cdb;
        rs_if.robs_calculated   = st_rc;
        rs_if.invalidated_rob_n = st_inv;
        rs_if.issue_ready       = st_ir;
        cyc++;
        #1;
        check("alloc_ready", 128'(rs_if.alloc_ready), 128'(model_q.size() < RS_DEPTH));
        check("occupancy",   128'(rs_if.occupancy),   128'(model_q.size()));
        check("res_empty",   128'(rs_if.res_empty),   128'(model_q.size() == 0));
        foreach (model_q[i]) begin
            if (sel < 0 && st_inv[model_q[i].rd_tag] && src_ok(model_q[i].src1) && src_ok(model_q[i].src2)) sel = i;
        end
        if (sel >= 0) begin
            e.cyc            = cyc;
            e.data.opcode    = model_q[sel].opcode;
            e.data.funct3    = model_q[sel].funct3;
            e.data.funct7    = model_q[sel].funct7;
            e.data.tag       = model_q[sel].rd_tag;
            e.data.pc        = model_q[sel].pc;
            e.data.src1_data = src_val(model_q[sel].src1);
            e.data.src2_data = src_val(model_q[sel].src2);
            e.ld_pc          = (model_q[sel].opcode == s_op_jalr) || (model_q[sel].opcode == s_op_br);
            e.upd_br         = (model_q[sel].opcode == s_op_br);
            e.jalr_ex        = (model_q[sel].opcode == s_op_jalr) && st_ir;
            e.jtag           = model_q[sel].rd_tag;
            exp_q.push_back(e);
        end
        foreach (model_q[i]) begin
            if (st_inv[model_q[i].rd_tag] && !(i == sel && st_ir)) nq.push_back(wake(model_q[i]));
        end
        if (st_av && model_q.size() < RS_DEPTH && st_inv[st_w.rd_tag]) nq.push_back(wake(st_w));
        if (do_rst) begin
            @(negedge clk);
            #1 rst = 1'b1;
            #1;
            check("rst_issue_valid", 128'(rs_if.issue_valid), 128'(0));
            check("rst_alloc_ready", 128'(rs_if.alloc_ready), 128'(1));
            check("rst_res_empty",   128'(rs_if.res_empty),   128'(1));
            check("rst_occupancy",   128'(rs_if.occupancy),   128'(0));
            check("rst_flags", 128'({rs_if.ld_pc_to_cdb, rs_if.update_br, rs_if.jalr_executed, rs_if.jalr_tag}), 128'(0));
            check("rst_issue_data",  128'(rs_if.issue_data),  128'(0));
            model_q.delete();
            rst = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            model_q = nq;
            #1;
        end
    endtask

    // Monitor: one prediction at most per cycle; any DUT issue without one is unexpected.
    always @(negedge clk) begin
        exp_t e;
        logic [$bits(alu_word)-1:0] act_d;
        if (!rst && cyc > 0) begin
            act_d = rs_if.issue_data;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("issue_valid", 128'(rs_if.issue_valid), 128'(1));
                check("issue_data",  128'(act_d), 128'(e.data));
                check("issue_flags", 128'({rs_if.ld_pc_to_cdb, rs_if.update_br, rs_if.jalr_executed}),
                                     128'({e.ld_pc, e.upd_br, e.jalr_ex}));
                check("jalr_tag",    128'(rs_if.jalr_tag), 128'(e.jtag));
            end else begin
                check("idle_issue_valid", 128'(rs_if.issue_valid), 128'(0));
                check("idle_issue_data",  128'(act_d), 128'(0));
                check("idle_flags", 128'({rs_if.ld_pc_to_cdb, rs_if.update_br, rs_if.jalr_executed, rs_if.jalr_tag}), 128'(0));
            end
        end
    end

    initial begin
        idle();
        rs_if.alloc_valid = 1'b0; rs_if.alloc_word = '0; rs_if.cdb = '0;
        rs_if.robs_calculated = '0; rs_if.invalidated_rob_n = '1; rs_if.issue_ready = 1'b0;
        #12;
        check("reset_alloc_ready", 128'(rs_if.alloc_ready), 128'(1));
        check("reset_res_empty",   128'(rs_if.res_empty),   128'(1));
        check("reset_occupancy",   128'(rs_if.occupancy),   128'(0));
        check("reset_issue_valid", 128'(rs_if.issue_valid), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Both sources ready: issue the cycle after alloc with 5/7.
        idle(); st_av = 1'b1; st_w = mk(s_op_alu, 1, 0, 5, 1, 0, 7, 1); st_ir = 1'b1; step(0);
        idle(); st_ir = 1'b1; step(0); step(0);

        // Pending src1 on tag 3: bypass while stalled, then latched value on issue.
        idle(); st_av = 1'b1; st_w = mk(s_op_alu, 0, 3, 0, 1, 0, 9, 2); step(0);
        idle(); step(0);
        idle(); st_rc[3] = 1'b1; st_cdb[3].data = 32'h2A; step(0);
        idle(); step(0);
        idle(); st_ir = 1'b1; step(0);

        // Fill to DEPTH, hold a fifth alloc until a slot has really been freed.
        for (int i = 0; i < RS_DEPTH; i++) begin
            idle(); st_av = 1'b1; st_w = mk(s_op_alui, 1, 0, 32'(i + 10), 1, 0, 32'(i), i); step(0);
        end
        idle(); st_av = 1'b1; st_w = mk(s_op_alu, 1, 0, 99, 1, 0, 98, 7); step(0);
        st_ir = 1'b1; step(0);
        step(0);
        idle(); st_ir = 1'b1;
        for (int i = 0; i < 5; i++) step(0);

        // Older waiting A, younger ready B; A later beats a ready C.
        idle(); st_av = 1'b1; st_w = mk(s_op_alu, 0, 5, 0, 1, 0, 1, 3); step(0);
        idle(); st_av = 1'b1; st_w = mk(s_op_alu, 1, 0, 2, 1, 0, 3, 4); step(0);
        idle(); step(0);
        idle(); st_av = 1'b1; st_w = mk(s_op_alu, 1, 0, 6, 1, 0, 7, 6); st_ir = 1'b1; step(0);
        idle(); step(0);
        idle(); st_rc[5] = 1'b1; st_cdb[5].data = 32'h55; st_ir = 1'b1; step(0);
        idle(); st_ir = 1'b1; step(0); step(0);

        // jalr with rd_tag 2, then a branch.
        idle(); st_av = 1'b1; st_w = mk(s_op_jalr, 1, 0, 32'h40, 1, 0, 0, 2); step(0);
        idle(); st_av = 1'b1; st_w = mk(s_op_br, 1, 0, 1, 1, 0, 1, 5); st_ir = 1'b1; step(0);
        idle(); st_ir = 1'b1; step(0); step(0);

        // Squash tag 4 while ready and issue_ready; same-cycle alloc on tag 4 is dropped.
        idle(); st_av = 1'b1; st_w = mk(s_op_alu, 1, 0, 4, 1, 0, 4, 4); step(0);
        idle(); step(0);
        idle(); st_inv[4] = 1'b0; st_ir = 1'b1; st_av = 1'b1; st_w = mk(s_op_alu, 1, 0, 8, 1, 0, 8, 4); step(0);
        idle(); st_ir = 1'b1; step(0);

        for (int n = 0; n < 1500; n++) begin
            rand_stim();
            step(0);
        end

        // Async reset in the middle of a stalled issue.
        idle(); st_av = 1'b1; st_w = mk(s_op_jalr, 1, 0, 1, 1, 0, 2, 3); step(0);
        idle(); step(1);
        for (int n = 0; n < 200; n++) begin
            rand_stim();
            step(0);
        end
        idle(); st_ir = 1'b1;
        for (int n = 0; n < 8; n++) step(0);

        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
